// File: rtl/fc_output_layer.sv
// fc_output_layer: final LeNet FC layer; ten parallel signed MACs over N serial activations, plus bias.
// Build option FC_OUT_SATURATE_EN: clamp scores to the signed M-bit range instead of wrapping.
module fc_output_layer #(
    parameter int unsigned M    = 32,
    parameter int unsigned F    = 16,
    parameter int unsigned N    = 84,
    parameter int unsigned ACCW = 2*M+8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M-1:0]    in_data,
    input  logic [10*M-1:0] in_w,
    input  logic [10*M-1:0] bias,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M-1:0]    out0,
    output logic [M-1:0]    out1,
    output logic [M-1:0]    out2,
    output logic [M-1:0]    out3,
    output logic [M-1:0]    out4,
    output logic [M-1:0]    out5,
    output logic [M-1:0]    out6,
    output logic [M-1:0]    out7,
    output logic [M-1:0]    out8,
    output logic [M-1:0]    out9
);
    localparam int unsigned K  = 10;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N-1);
`ifdef FC_OUT_SATURATE_EN
    localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-M+1){1'b0}}, {(M-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-M+1){1'b1}}, {(M-1){1'b0}}};
`endif

    typedef enum logic [1:0] {ACC, FINAL, OUT} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic signed [ACCW-1:0] acc       [K];
    logic [M-1:0]           score     [K];
    logic signed [2*M-1:0]  prod      [K];
    logic signed [ACCW-1:0] res       [K];
    logic [M-1:0]           score_nxt [K];

    // Per-class product, biased/rescaled result and M-bit reduction
    always_comb begin
        for (int k = 0; k < K; k++) begin
            prod[k] = (2*M)'($signed(in_data)) * (2*M)'($signed(in_w[k*M +: M]));
            res[k]  = (acc[k] + (ACCW'($signed(bias[k*M +: M])) <<< F)) >>> F;
`ifdef FC_OUT_SATURATE_EN
            if (res[k] > SMAX)
                score_nxt[k] = M'(SMAX);
            else if (res[k] < SMIN)
                score_nxt[k] = M'(SMIN);
            else
                score_nxt[k] = M'(res[k]);
`else
            score_nxt[k] = M'(res[k]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int k = 0; k < K; k++) begin
                acc[k]   <= '0;
                score[k] <= '0;
            end
        end else begin
            case (state)
                ACC: begin
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < K; k++)
                            acc[k] <= acc[k] + ACCW'(prod[k]);
                        if (cnt == LAST) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= FINAL;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                FINAL: begin
                    for (int k = 0; k < K; k++)
                        score[k] <= score_nxt[k];
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    // Scores stay held after the handshake until the next FINAL
                    if (out_ready) begin
                        for (int k = 0; k < K; k++)
                            acc[k] <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACC;
                    end
                end
                default: begin
                    state    <= ACC;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign out0 = score[0];
    assign out1 = score[1];
    assign out2 = score[2];
    assign out3 = score[3];
    assign out4 = score[4];
    assign out5 = score[5];
    assign out6 = score[6];
    assign out7 = score[7];
    assign out8 = score[8];
    assign out9 = score[9];

endmodule

// File: tb/tb_fc_output_layer.sv
// Self-checking bench for fc_output_layer (N=4): table of frames, expected scores queued per frame.
module tb_fc_output_layer;
    localparam int unsigned M = 32;
    localparam int unsigned F = 16;
    localparam int unsigned N = 4;

    typedef struct {
        logic [N-1:0][M-1:0]       x;
        logic [N-1:0][9:0][M-1:0]  w;
        logic [9:0][M-1:0]         b;
        logic [9:0][M-1:0]         e;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic [M-1:0] in_data;
    logic [10*M-1:0] in_w;
    logic [10*M-1:0] bias;
    logic out_valid;
    logic out_ready;
    logic [M-1:0] out0, out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic [9:0][M-1:0] outs;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0][M-1:0] exp_q [$];
    frame_t tbl [6];

    always #5 clk = ~clk;

    assign outs = {out9, out8, out7, out6, out5, out4, out3, out2, out1, out0};

    fc_output_layer #(.M(M), .F(F), .N(N), .ACCW(2*M+8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_w(in_w), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out5(out5), .out6(out6), .out7(out7), .out8(out8), .out9(out9)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Exact Q16.16 reference: wide accumulation, bias, floor shift, then saturate or wrap
    function automatic logic [31:0] model(input frame_t f, input int k);
        logic signed [71:0] a;
        a = '0;
        for (int i = 0; i < N; i++)
            a = a + 72'($signed(f.x[i])) * 72'($signed(f.w[i][k]));
        a = (a + (72'($signed(f.b[k])) <<< F)) >>> F;
`ifdef FC_OUT_SATURATE_EN
        if (a > 72'sd2147483647) return 32'h7FFF_FFFF;
        if (a < -72'sd2147483648) return 32'h8000_0000;
`endif
        return a[31:0];
    endfunction

    task automatic send_frame(input frame_t f, input int nbeats, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            int t;
            @(negedge clk);
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = f.x[i];
            in_w     = f.w[i];
            bias     = f.b;
            @(posedge clk);
            #1;
            if (gaps || i == nbeats-1) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end
            if (gaps && i != nbeats-1) @(posedge clk);
        end
        if (nbeats == N) exp_q.push_back(f.e);
    endtask

    task automatic get_result(input string name);
        logic [9:0][M-1:0] e;
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_scoreboard: got empty queue, want an entry", name);
        end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < 10; k++)
                check($sformatf("%s_out%0d", name, k), outs[k], e[k]);
        end
        if (out_ready) begin
            @(negedge clk);
            check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({name, "_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int best;
        logic [9:0] onehot;

        for (int j = 0; j < 6; j++) begin
            tbl[j].x = '0;
            tbl[j].w = '0;
            tbl[j].b = '0;
            tbl[j].e = '0;
        end
        // 0: x=1.0, W[k]=k*0.5 -> k*2.0
        for (int i = 0; i < N; i++) begin
            tbl[0].x[i] = 32'h0001_0000;
            for (int k = 0; k < 10; k++) tbl[0].w[i][k] = 32'(k) * 32'h0000_8000;
        end
        for (int k = 0; k < 10; k++) tbl[0].e[k] = 32'(k) * 32'h0002_0000;
        // 1: bias and negatives on class 3
        tbl[1].x[0] = 32'h0001_0000; tbl[1].x[1] = 32'hFFFE_0000;
        tbl[1].x[2] = 32'h0000_8000; tbl[1].x[3] = 32'h0000_0000;
        tbl[1].w[0][3] = 32'h0002_0000; tbl[1].w[1][3] = 32'h0001_0000;
        tbl[1].w[2][3] = 32'h0004_0000; tbl[1].w[3][3] = 32'h0007_0000;
        tbl[1].b[3] = 32'hFFFF_0000;
        tbl[1].e[3] = 32'h0001_0000;
        // 2: overflow on class 0
        for (int i = 0; i < N; i++) begin
            tbl[2].x[i] = 32'h7FFF_0000;
            tbl[2].w[i][0] = 32'h7FFF_0000;
        end
`ifdef FC_OUT_SATURATE_EN
        tbl[2].e[0] = 32'h7FFF_FFFF;
`else
        tbl[2].e[0] = 32'h0004_0000;
`endif
        // 3..5: random full-range frames against the reference model
        for (int j = 3; j < 6; j++) begin
            for (int i = 0; i < N; i++) begin
                tbl[j].x[i] = $urandom;
                for (int k = 0; k < 10; k++) tbl[j].w[i][k] = (j == 3) ? 32'($urandom_range(0, 32'h3_FFFF)) - 32'h2_0000 : $urandom;
            end
            for (int k = 0; k < 10; k++) tbl[j].b[k] = $urandom;
            for (int k = 0; k < 10; k++) tbl[j].e[k] = model(tbl[j], k);
        end

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_w = '0; bias = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 10; k++) check($sformatf("rst_out%0d", k), outs[k], 32'd0);
        rst = 1'b0;

        // Gapped frame with latency check: FINAL cycle, then OUT
        send_frame(tbl[0], N, 1'b1);
        @(negedge clk);
        check("lat_final_valid", 32'(out_valid), 32'd0);
        check("lat_final_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        get_result("gaps");

        send_frame(tbl[1], N, 1'b0);
        get_result("bias_neg");
        best = 0;
        for (int k = 1; k < 10; k++)
            if ($signed(outs[k]) > $signed(outs[best])) best = k;
        onehot = '0;
        onehot[best] = 1'b1;
        check("argmax_onehot", 32'(onehot), 32'h0000_0008);

        send_frame(tbl[2], N, 1'b0);
        get_result("overflow");

        for (int j = 3; j < 6; j++) begin
            send_frame(tbl[j], N, 1'b0);
            get_result($sformatf("rand%0d", j));
        end

        // Backpressure: hold scores for 5 cycles, then release
        out_ready = 1'b0;
        send_frame(tbl[1], N, 1'b0);
        get_result("bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_out3", c), outs[3], tbl[1].e[3]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        send_frame(tbl[0], N, 1'b0);
        get_result("bp_next");

        // Mid-frame reset after two beats discards the partial frame
        send_frame(tbl[3], 2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 10; k++) check($sformatf("mrst_out%0d", k), outs[k], 32'd0);
        send_frame(tbl[4], N, 1'b0);
        get_result("mrst_fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
